branch_target_predictor: RTL and testbench

//   Parametrised direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 29 ++
 rtl/branch_target_predictor.sv | 143 ++++++++++++++
 tb/tb_branch_target_predictor.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared MIPS pipeline types and BTB indexing helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int PC_WIDTH     = 32;
    localparam int BTB_ENTRIES  = 16;
    localparam int BTB_CNT_BITS = 2;

    // Helpers take PCs zero-extended to this width so any PC_WIDTH up to it works.
    localparam int BTB_PC_MAX   = 64;

    localparam int BTB_IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int BTB_TAG_BITS = PC_WIDTH - BTB_IDX_BITS - 2;

    typedef struct packed {
        logic                    valid;
        logic [BTB_TAG_BITS-1:0] tag;
        logic [PC_WIDTH-1:0]     target;
        logic [BTB_CNT_BITS-1:0] cnt;
    } btb_entry_t;

    function automatic logic [BTB_PC_MAX-1:0] btb_index(
        input logic [BTB_PC_MAX-1:0] pc,
        input int                    idx_bits
    );
        return (pc >> 2) & ((BTB_PC_MAX'(1) << idx_bits) - BTB_PC_MAX'(1));
    endfunction

    function automatic logic [BTB_PC_MAX-1:0] btb_tag(
        input logic [BTB_PC_MAX-1:0] pc,
        input int                    idx_bits
    );
        return pc >> (idx_bits + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module : sat_counter
// Brief  : Combinational next value of an up/down saturating counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] i_cnt,
    input  logic                i_inc,
    output logic [CNT_BITS-1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_inc) begin
            if (i_cnt != '1) begin
                o_cnt = i_cnt + CNT_BITS'(1);
            end
        end else if (i_cnt != '0) begin
            o_cnt = i_cnt - CNT_BITS'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// Module : branch_target_predictor
// Brief  : Direct-mapped BTB with per-entry saturating direction counters.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_target_predictor #(
    parameter int PC_WIDTH   = mips_pkg::PC_WIDTH,
    parameter int ENTRIES    = 16,
    parameter int CNT_BITS   = 2,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  ClockIn,
    input  logic                  Reset,
    input  logic [PC_WIDTH-1:0]   LookupPC,
    output logic                  PredHit,
    output logic                  PredTaken,
    output logic [PC_WIDTH-1:0]   PredTarget,
    input  logic                  UpdValid,
    input  logic [PC_WIDTH-1:0]   UpdPC,
    input  logic                  UpdTaken,
    input  logic [PC_WIDTH-1:0]   UpdTarget,
    input  logic                  UpdPredTaken,
    input  logic [PC_WIDTH-1:0]   UpdPredTarget,
    output logic                  Mispredict,
    input  logic                  Invalidate,
    output logic [STAT_WIDTH-1:0] StatUpdates,
    output logic [STAT_WIDTH-1:0] StatMispredicts
);

    import mips_pkg::*;

    localparam int c_IDX_BITS = $clog2(ENTRIES);
    localparam int c_TAG_BITS = PC_WIDTH - c_IDX_BITS - 2;
    localparam logic [CNT_BITS-1:0] c_CNT_ALLOC = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] c_CNT_RESET = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_entries_check
        $error("branch_target_predictor: ENTRIES must be a power of two >= 2");
    end
    if ((CNT_BITS < 1) || (CNT_BITS > 4)) begin : g_cnt_check
        $error("branch_target_predictor: CNT_BITS must be 1..4");
    end
    if (PC_WIDTH > BTB_PC_MAX) begin : g_pc_check
        $error("branch_target_predictor: PC_WIDTH exceeds helper width");
    end

    // Same fields as mips_pkg::btb_entry_t, sized for this instance's geometry.
    typedef struct packed {
        logic                  valid;
        logic [c_TAG_BITS-1:0] tag;
        logic [PC_WIDTH-1:0]   target;
        logic [CNT_BITS-1:0]   cnt;
    } entry_t;

    entry_t                r_entries [ENTRIES];
    logic [STAT_WIDTH-1:0] r_stat_updates;
    logic [STAT_WIDTH-1:0] r_stat_mispredicts;

    logic [c_IDX_BITS-1:0] w_lk_idx;
    logic [c_TAG_BITS-1:0] w_lk_tag;
    entry_t                w_lk_entry;
    logic                  w_lk_hit;
    logic [c_IDX_BITS-1:0] w_upd_idx;
    logic [c_TAG_BITS-1:0] w_upd_tag;
    entry_t                w_upd_entry;
    logic                  w_upd_hit;
    logic [CNT_BITS-1:0]   w_cnt_next;
    logic                  w_mispredict;

    assign w_lk_idx    = c_IDX_BITS'(btb_index(BTB_PC_MAX'(LookupPC), c_IDX_BITS));
    assign w_lk_tag    = c_TAG_BITS'(btb_tag(BTB_PC_MAX'(LookupPC), c_IDX_BITS));
    assign w_lk_entry  = r_entries[w_lk_idx];
    assign w_lk_hit    = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

    assign w_upd_idx   = c_IDX_BITS'(btb_index(BTB_PC_MAX'(UpdPC), c_IDX_BITS));
    assign w_upd_tag   = c_TAG_BITS'(btb_tag(BTB_PC_MAX'(UpdPC), c_IDX_BITS));
    assign w_upd_entry = r_entries[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

    assign w_mispredict = UpdValid &&
                          ((UpdTaken != UpdPredTaken) ||
                           (UpdTaken && (UpdTarget != UpdPredTarget)));

    sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_sat_counter (
        .i_cnt (w_upd_entry.cnt),
        .i_inc (UpdTaken),
        .o_cnt (w_cnt_next)
    );

    // Invalidate takes priority over a same-cycle update; stats still count it.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i].valid  <= 1'b0;
                r_entries[i].tag    <= '0;
                r_entries[i].target <= '0;
                r_entries[i].cnt    <= c_CNT_RESET;
            end
        end else if (Invalidate) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (UpdValid) begin
            if (w_upd_hit) begin
                r_entries[w_upd_idx].cnt <= w_cnt_next;
                if (UpdTaken) begin
                    r_entries[w_upd_idx].target <= UpdTarget;
                end
            end else if (UpdTaken) begin
                r_entries[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag,
                                          target: UpdTarget, cnt: c_CNT_ALLOC};
            end
        end
    end

    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            r_stat_updates     <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (UpdValid && (r_stat_updates != '1)) begin
                r_stat_updates <= r_stat_updates + STAT_WIDTH'(1);
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + STAT_WIDTH'(1);
            end
        end
    end

    assign PredHit         = w_lk_hit;
    assign PredTaken       = w_lk_hit && w_lk_entry.cnt[CNT_BITS-1];
    assign PredTarget      = w_lk_hit ? w_lk_entry.target : '0;
    assign Mispredict      = w_mispredict;
    assign StatUpdates     = r_stat_updates;
    assign StatMispredicts = r_stat_mispredicts;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// Module : tb_branch_target_predictor
// Brief  : Directed scoreboard bench for branch_target_predictor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

    localparam int PCW = 32;
    localparam int SW  = 4;

    logic           clk = 1'b0;
    logic           Reset;
    logic [PCW-1:0] LookupPC;
    logic           PredHit;
    logic           PredTaken;
    logic [PCW-1:0] PredTarget;
    logic           UpdValid;
    logic [PCW-1:0] UpdPC;
    logic           UpdTaken;
    logic [PCW-1:0] UpdTarget;
    logic           UpdPredTaken;
    logic [PCW-1:0] UpdPredTarget;
    logic           Mispredict;
    logic           Invalidate;
    logic [SW-1:0]  StatUpdates;
    logic [SW-1:0]  StatMispredicts;

    branch_target_predictor #(
        .PC_WIDTH   (PCW),
        .ENTRIES    (16),
        .CNT_BITS   (2),
        .STAT_WIDTH (SW)
    ) dut (
        .ClockIn         (clk),
        .Reset           (Reset),
        .LookupPC        (LookupPC),
        .PredHit         (PredHit),
        .PredTaken       (PredTaken),
        .PredTarget      (PredTarget),
        .UpdValid        (UpdValid),
        .UpdPC           (UpdPC),
        .UpdTaken        (UpdTaken),
        .UpdTarget       (UpdTarget),
        .UpdPredTaken    (UpdPredTaken),
        .UpdPredTarget   (UpdPredTarget),
        .Mispredict      (Mispredict),
        .Invalidate      (Invalidate),
        .StatUpdates     (StatUpdates),
        .StatMispredicts (StatMispredicts)
    );

    always #5 clk = ~clk;

    // kind 0: {hit, taken, target}; kind 1: mispredict; kind 2: {updates, mispredicts}
    typedef struct {
        string       name;
        int          kind;
        logic [39:0] want;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [39:0] mon_got;
    int          vectors     = 0;
    int          miscompares = 0;

    function automatic logic [39:0] observe(input int kind);
        case (kind)
            0:       return {6'b0, PredHit, PredTaken, PredTarget};
            1:       return {39'b0, Mispredict};
            default: return {32'b0, StatUpdates, StatMispredicts};
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = observe(mon_e.kind);
            vectors++;
            if (mon_got !== mon_e.want) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", mon_e.name, mon_got, mon_e.want);
            end
        end
    end

    task automatic apply(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic upt,
                         input logic [31:0] uptgt, input logic inv);
        @(posedge clk);
        #1;
        LookupPC      = lk;
        UpdValid      = uv;
        UpdPC         = upc;
        UpdTaken      = ut;
        UpdTarget     = utgt;
        UpdPredTaken  = upt;
        UpdPredTarget = uptgt;
        Invalidate    = inv;
    endtask

    task automatic idle(input logic [31:0] lk);
        apply(lk, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic exp_pred(input string n, input logic h, input logic t, input logic [31:0] tg);
        exp_q.push_back('{name: n, kind: 0, want: {6'b0, h, t, tg}});
    endtask

    task automatic exp_misp(input string n, input logic m);
        exp_q.push_back('{name: n, kind: 1, want: {39'b0, m}});
    endtask

    task automatic exp_stats(input string n, input logic [3:0] u, input logic [3:0] m);
        exp_q.push_back('{name: n, kind: 2, want: {32'b0, u, m}});
    endtask

    initial begin
        Reset = 1'b0;
        LookupPC = '0; UpdValid = 1'b0; UpdPC = '0; UpdTaken = 1'b0; UpdTarget = '0;
        UpdPredTaken = 1'b0; UpdPredTarget = '0; Invalidate = 1'b0;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;

        idle(32'h40);
        exp_pred("reset_lookup", 1'b0, 1'b0, 32'h0);
        exp_stats("reset_stats", 4'd0, 4'd0);
        exp_misp("reset_misp", 1'b0);

        apply(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        exp_misp("alloc_misp", 1'b1);
        exp_pred("alloc_same_cycle", 1'b0, 1'b0, 32'h0);

        idle(32'h40);
        exp_pred("alloc_visible", 1'b1, 1'b1, 32'h80);
        exp_stats("alloc_stats", 4'd1, 4'd1);

        apply(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
        exp_misp("nt1_misp", 1'b1);
        exp_pred("cnt2", 1'b1, 1'b1, 32'h80);

        apply(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
        exp_pred("cnt1", 1'b1, 1'b0, 32'h80);
        exp_stats("nt_stats", 4'd2, 4'd2);

        apply(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exp_misp("nt_correct", 1'b0);
        exp_pred("cnt0", 1'b1, 1'b0, 32'h80);
        exp_stats("nt3_stats", 4'd3, 4'd3);

        idle(32'h40);
        exp_pred("cnt0_hold", 1'b1, 1'b0, 32'h80);
        exp_stats("idle_stats", 4'd4, 4'd3);

        // From a saturated 0, one taken update must still predict not-taken.
        apply(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        exp_pred("cnt0_after_sat", 1'b1, 1'b0, 32'h80);
        apply(32'h40, 1'b1, 32'h40, 1'b1, 32'h84, 1'b0, 32'h0, 1'b0);
        exp_pred("cnt1_after_sat", 1'b1, 1'b0, 32'h80);
        exp_stats("t_stats", 4'd5, 4'd4);

        apply(32'h40, 1'b1, 32'h440, 1'b1, 32'h900, 1'b0, 32'h0, 1'b0);
        exp_pred("target_update", 1'b1, 1'b1, 32'h84);
        exp_stats("pre_alias_stats", 4'd6, 4'd5);

        idle(32'h40);
        exp_pred("alias_evicted", 1'b0, 1'b0, 32'h0);
        exp_stats("alias_stats", 4'd7, 4'd6);

        apply(32'h440, 1'b1, 32'h440, 1'b0, 32'h0, 1'b1, 32'h900, 1'b0);
        exp_pred("alias_resident", 1'b1, 1'b1, 32'h900);
        exp_misp("same_cycle_misp", 1'b1);

        apply(32'h440, 1'b1, 32'h440, 1'b1, 32'hA00, 1'b1, 32'h900, 1'b0);
        exp_pred("same_cycle_next", 1'b1, 1'b0, 32'h900);
        exp_misp("target_misp", 1'b1);
        exp_stats("sc_stats", 4'd8, 4'd7);

        apply(32'h440, 1'b1, 32'h440, 1'b1, 32'hA00, 1'b1, 32'hA00, 1'b0);
        exp_misp("correct_taken", 1'b0);
        exp_pred("new_target", 1'b1, 1'b1, 32'hA00);

        apply(32'h440, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        exp_pred("cnt3", 1'b1, 1'b1, 32'hA00);
        exp_stats("ct_stats", 4'd10, 4'd8);

        apply(32'h440, 1'b1, 32'h440, 1'b1, 32'hB00, 1'b1, 32'hA00, 1'b1);
        exp_pred("nt_miss_no_alloc", 1'b1, 1'b1, 32'hA00);
        exp_misp("inval_misp", 1'b1);

        idle(32'h440);
        exp_pred("invalidated", 1'b0, 1'b0, 32'h0);
        exp_stats("inval_stats", 4'd12, 4'd9);

        @(posedge clk);
        #1 Reset = 1'b0;
        @(posedge clk);
        #1 Reset = 1'b1;

        for (int j = 0; j < 20; j++) begin
            apply(32'h80, 1'b1, 32'h80, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
            exp_misp("sat_misp", 1'b1);
            exp_stats($sformatf("sat_stats_%0d", j), 4'((j > 15) ? 15 : j), 4'((j > 15) ? 15 : j));
        end
        apply(32'h80, 1'b1, 32'h80, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
        exp_pred("sat_lookup", 1'b1, 1'b1, 32'h10);
        exp_stats("sat_final", 4'd15, 4'd15);

        // Asynchronous reset: checked at the negedge, before the next rising edge.
        @(posedge clk);
        #1 Reset = 1'b0;
        exp_pred("async_rst_pred", 1'b0, 1'b0, 32'h0);
        exp_stats("async_rst_stats", 4'd0, 4'd0);
        exp_misp("async_rst_misp", 1'b1);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
